// File: rtl/control_unit.sv
// Multicycle control FSM for the accumulator processor: sequences fetch, decode,
// execute and memory-writeback, and drives the datapath strobes and mux selects.
module control_unit #(
    parameter int OPCODE_WIDTH = 5
) (
    input  logic                    clock,
    input  logic                    control_reset,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    flag_Z,
    input  logic                    flag_N,
    output logic                    ir_wr,
    output logic                    pc_wr,
    output logic                    pc_src,
    output logic                    mem_wr,
    output logic                    acc_wr,
    output logic [1:0]              acc_src,
    output logic                    alu_op,
    output logic                    alu_b_src,
    output logic                    status_wr,
    output logic                    halted,
    output logic [2:0]              state
);

    typedef enum logic [2:0] {
        S_START  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_STO  = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_LD   = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(5);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(6);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = OPCODE_WIDTH'(7);
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = OPCODE_WIDTH'(8);
    localparam logic [OPCODE_WIDTH-1:0] OP_BNE  = OPCODE_WIDTH'(9);
    localparam logic [OPCODE_WIDTH-1:0] OP_BGT  = OPCODE_WIDTH'(10);
    localparam logic [OPCODE_WIDTH-1:0] OP_BGE  = OPCODE_WIDTH'(11);
    localparam logic [OPCODE_WIDTH-1:0] OP_BLT  = OPCODE_WIDTH'(12);
    localparam logic [OPCODE_WIDTH-1:0] OP_BLE  = OPCODE_WIDTH'(13);
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = OPCODE_WIDTH'(14);

    state_t cur_state;
    state_t next_state;
    logic   is_branch;
    logic   branch_taken;

    // Reset forces START, where every output decodes to 0 without a clock edge.
    always_ff @(posedge clock or posedge control_reset) begin
        if (control_reset) begin
            cur_state <= S_START;
        end else begin
            cur_state <= next_state;
        end
    end

    always_comb begin
        is_branch    = 1'b0;
        branch_taken = 1'b0;
        case (opcode)
            OP_BEQ:  begin is_branch = 1'b1; branch_taken = flag_Z;              end
            OP_BNE:  begin is_branch = 1'b1; branch_taken = !flag_Z;             end
            OP_BGT:  begin is_branch = 1'b1; branch_taken = !flag_Z && !flag_N;  end
            OP_BGE:  begin is_branch = 1'b1; branch_taken = !flag_N;             end
            OP_BLT:  begin is_branch = 1'b1; branch_taken = flag_N;              end
            OP_BLE:  begin is_branch = 1'b1; branch_taken = flag_Z || flag_N;    end
            OP_JMP:  begin is_branch = 1'b1; branch_taken = 1'b1;                end
            default: begin is_branch = 1'b0; branch_taken = 1'b0;                end
        endcase
    end

    always_comb begin
        next_state = S_START;
        ir_wr      = 1'b0;
        pc_wr      = 1'b0;
        pc_src     = 1'b0;
        mem_wr     = 1'b0;
        acc_wr     = 1'b0;
        acc_src    = 2'b00;
        alu_op     = 1'b0;
        alu_b_src  = 1'b0;
        status_wr  = 1'b0;
        halted     = 1'b0;
        case (cur_state)
            S_START: next_state = S_FETCH;
            S_FETCH: begin
                ir_wr      = 1'b1;
                pc_wr      = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: next_state = S_EXEC;
            S_EXEC: begin
                next_state = S_FETCH;
                case (opcode)
                    OP_HLT: next_state = S_HALT;
                    OP_STO: mem_wr = 1'b1;
                    OP_LDI: begin
                        acc_wr    = 1'b1;
                        acc_src   = 2'b10;
                        status_wr = 1'b1;
                    end
                    OP_ADDI, OP_SUBI: begin
                        acc_wr    = 1'b1;
                        alu_b_src = 1'b1;
                        alu_op    = (opcode == OP_SUBI);
                        status_wr = 1'b1;
                    end
                    // Memory operands: the read address is presented here, data arrives in MEM.
                    OP_LD, OP_ADD, OP_SUB: next_state = S_MEM;
                    default: begin
                        if (is_branch) begin
                            pc_wr  = branch_taken;
                            pc_src = 1'b1;
                        end
                    end
                endcase
            end
            S_MEM: begin
                next_state = S_FETCH;
                case (opcode)
                    OP_LD: begin
                        acc_wr    = 1'b1;
                        acc_src   = 2'b01;
                        status_wr = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        acc_wr    = 1'b1;
                        alu_op    = (opcode == OP_SUB);
                        status_wr = 1'b1;
                    end
                    default: next_state = S_FETCH;
                endcase
            end
            S_HALT: begin
                halted     = 1'b1;
                next_state = S_HALT;
            end
            default: next_state = S_START;
        endcase
    end

    assign state = cur_state;

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit: state sequences, per-opcode strobes,
// branch conditions, HALT stickiness and asynchronous reset behaviour.
module tb_control_unit;

    logic       clock;
    logic       control_reset;
    logic [4:0] opcode;
    logic       flag_Z;
    logic       flag_N;
    logic       ir_wr, pc_wr, pc_src, mem_wr, acc_wr;
    logic [1:0] acc_src;
    logic       alu_op, alu_b_src, status_wr, halted;
    logic [2:0] state;

    int checks = 0;
    int passed = 0;

    control_unit #(.OPCODE_WIDTH(5)) dut (
        .clock(clock), .control_reset(control_reset), .opcode(opcode),
        .flag_Z(flag_Z), .flag_N(flag_N), .ir_wr(ir_wr), .pc_wr(pc_wr),
        .pc_src(pc_src), .mem_wr(mem_wr), .acc_wr(acc_wr), .acc_src(acc_src),
        .alu_op(alu_op), .alu_b_src(alu_b_src), .status_wr(status_wr),
        .halted(halted), .state(state)
    );

    always #5 clock = ~clock;

    // Observed word: {state, ir_wr, pc_wr, pc_src, mem_wr, acc_wr, acc_src, alu_op, alu_b_src, status_wr, halted}
    logic [13:0] obs;
    assign obs = {state, ir_wr, pc_wr, pc_src, mem_wr, acc_wr, acc_src, alu_op, alu_b_src, status_wr, halted};

    localparam logic [13:0] E_ZERO     = {3'd0, 11'b00000000000};
    localparam logic [13:0] E_FETCH    = {3'd1, 11'b11000000000};
    localparam logic [13:0] E_DECODE   = {3'd2, 11'b00000000000};
    localparam logic [13:0] E_EXEC0    = {3'd3, 11'b00000000000};
    localparam logic [13:0] E_LDI      = {3'd3, 11'b00001100010};
    localparam logic [13:0] E_ADDI     = {3'd3, 11'b00001000110};
    localparam logic [13:0] E_SUBI     = {3'd3, 11'b00001001110};
    localparam logic [13:0] E_STO      = {3'd3, 11'b00010000000};
    localparam logic [13:0] E_BR_TAKEN = {3'd3, 11'b01100000000};
    localparam logic [13:0] E_BR_NOT   = {3'd3, 11'b00100000000};
    localparam logic [13:0] E_MEM_LD   = {3'd4, 11'b00001010010};
    localparam logic [13:0] E_MEM_ADD  = {3'd4, 11'b00001000010};
    localparam logic [13:0] E_MEM_SUB  = {3'd4, 11'b00001001010};
    localparam logic [13:0] E_HALT     = {3'd5, 11'b00000000001};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        tick();
        checks++;
        if (obs !== E_ZERO) $display("[TB] FAIL reset_hold: got %h expected %h", obs, E_ZERO);
        else passed++;
        opcode = 5'd4;
        tick();
        checks++;
        if (obs !== E_ZERO) $display("[TB] FAIL reset_hold2: got %h expected %h", obs, E_ZERO);
        else passed++;
        @(negedge clock);
        control_reset = 1'b0;
        #1;
        checks++;
        if (obs !== E_ZERO) $display("[TB] FAIL reset_start: got %h expected %h", obs, E_ZERO);
        else passed++;
        tick();
        checks++;
        if (obs !== E_FETCH) $display("[TB] FAIL first_fetch: got %h expected %h", obs, E_FETCH);
        else passed++;
    endtask

    task automatic test_ldi();
        logic [13:0] seq [3];
        seq = '{E_DECODE, E_LDI, E_FETCH};
        opcode = 5'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== seq[i]) $display("[TB] FAIL ldi_step%0d: got %h expected %h", i, obs, seq[i]);
            else passed++;
        end
    endtask

    task automatic test_alu_ops();
        logic [4:0]  ops  [7];
        logic [13:0] ex   [7];
        logic [13:0] mm   [7];
        bit          four [7];
        ops  = '{5'd4, 5'd6, 5'd5, 5'd7, 5'd2, 5'd15, 5'd16};
        ex   = '{E_EXEC0, E_EXEC0, E_ADDI, E_SUBI, E_EXEC0, E_EXEC0, E_EXEC0};
        mm   = '{E_MEM_ADD, E_MEM_SUB, E_ZERO, E_ZERO, E_MEM_LD, E_ZERO, E_ZERO};
        four = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        flag_Z = 1'b1;
        flag_N = 1'b1;
        for (int i = 0; i < 7; i++) begin
            opcode = ops[i];
            #1;
            checks++;
            if (obs !== E_FETCH) $display("[TB] FAIL op%0d_fetch_ignores_opcode: got %h expected %h", ops[i], obs, E_FETCH);
            else passed++;
            tick();
            checks++;
            if (obs !== E_DECODE) $display("[TB] FAIL op%0d_decode: got %h expected %h", ops[i], obs, E_DECODE);
            else passed++;
            tick();
            checks++;
            if (obs !== ex[i]) $display("[TB] FAIL op%0d_exec: got %h expected %h", ops[i], obs, ex[i]);
            else passed++;
            if (four[i]) begin
                tick();
                checks++;
                if (obs !== mm[i]) $display("[TB] FAIL op%0d_mem: got %h expected %h", ops[i], obs, mm[i]);
                else passed++;
            end
            tick();
            checks++;
            if (obs !== E_FETCH) $display("[TB] FAIL op%0d_refetch: got %h expected %h", ops[i], obs, E_FETCH);
            else passed++;
        end
        flag_Z = 1'b0;
        flag_N = 1'b0;
    endtask

    task automatic test_branches();
        logic [4:0] bops [18];
        bit         bz   [18];
        bit         bn   [18];
        bit         btk  [18];
        logic [13:0] want;
        bops = '{5'd8, 5'd8, 5'd10, 5'd10, 5'd10, 5'd10, 5'd13, 5'd13, 5'd13,
                 5'd13, 5'd9, 5'd9, 5'd11, 5'd11, 5'd12, 5'd12, 5'd14, 5'd14};
        bz   = '{1, 0, 0, 0, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1};
        bn   = '{0, 0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 1};
        btk  = '{1, 0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 1, 1, 0, 1, 1};
        for (int i = 0; i < 18; i++) begin
            opcode = bops[i];
            flag_Z = bz[i];
            flag_N = bn[i];
            tick();
            tick();
            want = btk[i] ? E_BR_TAKEN : E_BR_NOT;
            checks++;
            if (obs !== want)
                $display("[TB] FAIL branch_op%0d_z%0d_n%0d: got %h expected %h", bops[i], bz[i], bn[i], obs, want);
            else passed++;
            tick();
            checks++;
            if (obs !== E_FETCH) $display("[TB] FAIL branch%0d_refetch: got %h expected %h", i, obs, E_FETCH);
            else passed++;
        end
        flag_Z = 1'b0;
        flag_N = 1'b0;
    endtask

    task automatic test_sto();
        int mem_cycles = 0;
        int other_wr = 0;
        opcode = 5'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (mem_wr === 1'b1) mem_cycles++;
            if (acc_wr !== 1'b0 || status_wr !== 1'b0) other_wr++;
            if (i == 1) begin
                checks++;
                if (obs !== E_STO) $display("[TB] FAIL sto_exec: got %h expected %h", obs, E_STO);
                else passed++;
            end
        end
        checks++;
        if (mem_cycles != 1 || other_wr != 0)
            $display("[TB] FAIL sto_strobe_count: got mem_wr=%0d others=%0d expected 1 and 0", mem_cycles, other_wr);
        else passed++;
        checks++;
        if (obs !== E_FETCH) $display("[TB] FAIL sto_refetch: got %h expected %h", obs, E_FETCH);
        else passed++;
    endtask

    task automatic test_halt();
        int bad = 0;
        opcode = 5'd0;
        tick();
        tick();
        checks++;
        if (obs !== E_EXEC0) $display("[TB] FAIL hlt_exec: got %h expected %h", obs, E_EXEC0);
        else passed++;
        tick();
        checks++;
        if (obs !== E_HALT) $display("[TB] FAIL hlt_enter: got %h expected %h", obs, E_HALT);
        else passed++;
        for (int i = 0; i < 10; i++) begin
            opcode = 5'($urandom);
            flag_Z = 1'($urandom);
            flag_N = 1'($urandom);
            tick();
            if (obs !== E_HALT) bad++;
        end
        checks++;
        if (bad != 0) $display("[TB] FAIL halt_sticky: got %0d deviating cycles expected 0", bad);
        else passed++;
        #2;
        control_reset = 1'b1;
        #1;
        checks++;
        if (obs !== E_ZERO) $display("[TB] FAIL halt_async_reset: got %h expected %h", obs, E_ZERO);
        else passed++;
        @(negedge clock);
        control_reset = 1'b0;
        flag_Z = 1'b0;
        flag_N = 1'b0;
        tick();
        checks++;
        if (obs !== E_FETCH) $display("[TB] FAIL halt_restart_fetch: got %h expected %h", obs, E_FETCH);
        else passed++;
    endtask

    task automatic test_reset_mid_ld();
        logic [13:0] seq [3];
        seq = '{E_DECODE, E_EXEC0, E_FETCH};
        opcode = 5'd2;
        tick();
        tick();
        tick();
        checks++;
        if (obs !== E_MEM_LD) $display("[TB] FAIL ld_mem_before_reset: got %h expected %h", obs, E_MEM_LD);
        else passed++;
        #2;
        control_reset = 1'b1;
        #1;
        checks++;
        if (acc_wr !== 1'b0 || obs !== E_ZERO)
            $display("[TB] FAIL ld_mid_reset: got %h expected %h", obs, E_ZERO);
        else passed++;
        tick();
        @(negedge clock);
        control_reset = 1'b0;
        opcode = 5'b11111;
        #1;
        checks++;
        if (obs !== E_ZERO) $display("[TB] FAIL ld_reset_start: got %h expected %h", obs, E_ZERO);
        else passed++;
        tick();
        checks++;
        if (obs !== E_FETCH) $display("[TB] FAIL nop_fetch: got %h expected %h", obs, E_FETCH);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== seq[i]) $display("[TB] FAIL nop31_step%0d: got %h expected %h", i, obs, seq[i]);
            else passed++;
        end
    endtask

    initial begin
        clock         = 1'b0;
        control_reset = 1'b1;
        opcode        = 5'd0;
        flag_Z        = 1'b0;
        flag_N        = 1'b0;
        test_reset();
        test_ldi();
        test_alu_ops();
        test_branches();
        test_sto();
        test_halt();
        test_reset_mid_ld();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
